// File: rtl/seq_array_mult_if.sv
// Handshake and operand bundle for the sequential array multiplier.
// The master side issues Start with its operands; the slave side returns the
// product together with the Busy/Done status flags.
interface seq_array_mult_if #(
  parameter int N = 4
);
  logic           Start;
  logic           Tc;
  logic [N-1:0]   X;
  logic [N-1:0]   Y;
  logic [2*N-1:0] Z;
  logic           Busy;
  logic           Done;

  modport master (output Start, Tc, X, Y, input Z, Busy, Done);
  modport slave  (input Start, Tc, X, Y, output Z, Busy, Done);
endinterface

// File: rtl/seq_array_mult.sv
// Sequential N x N shift-add multiplier, one multiplier bit per cycle.
// Handles unsigned and two's-complement operands, chosen per operation by Tc.
// For signed operation the MSB partial product is subtracted, because that bit
// carries weight -2^(N-1). Accumulation is modulo 2^(2N), so it cannot overflow.
module seq_array_mult #(
  parameter int N = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  seq_array_mult_if.slave   bus
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_next;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [N-1:0]   mplier;
  logic           tc_reg;
  logic [CW-1:0]  cnt;
  logic           last_iter;
  logic           accept;

  // Widen an operand to the product width: sign-extend for signed mode,
  // zero-extend otherwise.
  function automatic logic [2*N-1:0] extend(input logic [N-1:0] v, input logic tc);
    logic signed [N-1:0] sv;
    sv = $signed(v);
    extend = tc ? {{N{sv[N-1]}}, v} : {{N{1'b0}}, v};
  endfunction

  // A new operation is taken only from IDLE or DONE; Start during RUN is dropped.
  assign accept    = bus.Start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: RUN lasts exactly N cycles, DONE exactly one.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = bus.Start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accumulator update for the current multiplier bit; the final signed bit subtracts.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      if (tc_reg && last_iter) acc_next = acc - mcand;
      else                     acc_next = acc + mcand;
    end
  end

  // Operand capture, shift-add iteration and result hand-off into Z.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      tc_reg <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      bus.Z  <= '0;
    end else if (accept) begin
      mcand  <= extend(bus.X, bus.Tc);
      mplier <= bus.Y;
      tc_reg <= bus.Tc;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last_iter) begin
        cnt   <= '0;
        bus.Z <= acc_next;
      end else begin
        cnt   <= cnt + CW'(1);
      end
    end
  end

  // Registered status flags decoded from the upcoming state, so neither has
  // a combinational path from the inputs and they can never overlap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.Busy <= 1'b0;
      bus.Done <= 1'b0;
    end else begin
      bus.Busy <= (state_next == RUN);
      bus.Done <= (state_next == DONE);
    end
  end

endmodule
